// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// FSM states and transaction owner encoding.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_t;

   typedef enum logic {
      OWN_DATA,
      OWN_FETCH
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority pick between data and fetch ports.
// Data wins unless fetch has been starved STARVE_LIMIT times in a row.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic if_req,
   input  logic if_flush,
   input  logic dm_req,
   output logic pick_valid,
   output logic pick_fetch
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   logic          fetch_ok;
   logic          force_f;

   // a flushed fetch is not a candidate this cycle
   always_comb begin
      fetch_ok   = if_req & ~if_flush;
      force_f    = fetch_ok & (starve_cnt == LIM);
      pick_valid = dm_req | fetch_ok;
      pick_fetch = force_f | (fetch_ok & ~dm_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (arb_en) begin
         if (!if_req) begin
            starve_cnt <= '0;
         end else if (pick_valid) begin
            if (pick_fetch)
               starve_cnt <= '0;
            else if (starve_cnt != LIM)
               starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store.
// One outstanding transaction, req/gnt/rvalid toward memory.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   input  logic             if_flush,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_valid,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [WIDTH-1:0] dm_addr,
   input  logic [WIDTH-1:0] dm_wdata,
   output logic [WIDTH-1:0] dm_rdata,
   output logic             dm_valid,
   output logic             stall_f,
   output logic             stall_m,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             protocol_err
);

   state_t state;
   owner_t owner;
   logic   discard;
   logic   pick_valid;
   logic   pick_fetch;
   logic   own_f;
   logic   resp_hit;

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (state == IDLE),
      .if_req    (if_req),
      .if_flush  (if_flush),
      .dm_req    (dm_req),
      .pick_valid(pick_valid),
      .pick_fetch(pick_fetch)
   );

   // reset masks a response arriving in the same cycle
   always_comb begin
      own_f    = (owner == OWN_FETCH);
      resp_hit = ~rst & (state == RESP) & mem_rvalid;
      dm_valid = resp_hit & ~own_f;
      if_valid = resp_hit & own_f & ~discard & ~if_flush;
      if_rdata = mem_rdata;
      dm_rdata = mem_rdata;
      stall_f  = if_req & ~if_valid & ~if_flush;
      stall_m  = dm_req & ~dm_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= OWN_DATA;
         discard      <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (mem_rvalid && state != RESP)
            protocol_err <= 1'b1;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  state   <= REQ;
                  discard <= 1'b0;
                  mem_req <= 1'b1;
                  if (pick_fetch) begin
                     owner     <= OWN_FETCH;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end else begin
                     owner     <= OWN_DATA;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end
               end
            end
            REQ: begin
               if (own_f && if_flush && !mem_gnt) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end else if (mem_gnt) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (own_f && if_flush)
                     discard <= 1'b1;
               end
            end
            RESP: begin
               if (own_f && if_flush)
                  discard <= 1'b1;
               if (mem_rvalid) begin
                  state   <= IDLE;
                  discard <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
